// File: rtl/cam_lookup_controller.sv
// Learning L2 forwarding controller in front of an external CAM: learns source MACs,
// looks up the destination and returns a forward / flood / filter decision per frame.
module cam_lookup_controller #(
    parameter int unsigned KEY_WIDTH      = 48,
    parameter int unsigned TABLE_DEPTH    = 32,
    parameter int unsigned PORT_WIDTH     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           request_valid,
    output logic                           request_ready,
    input  logic [KEY_WIDTH-1:0]           destination_mac,
    input  logic [KEY_WIDTH-1:0]           source_mac,
    input  logic [PORT_WIDTH-1:0]          source_port,
    output logic [KEY_WIDTH-1:0]           cam_key,
    output logic                           cam_write_enable,
    output logic                           cam_match_enable,
    input  logic [$clog2(TABLE_DEPTH)-1:0] cam_match_index,
    input  logic                           cam_match_valid,
    input  logic                           cam_no_match,
    output logic                           response_valid,
    input  logic                           response_ready,
    output logic [PORT_WIDTH-1:0]          response_port,
    output logic                           response_flood,
    output logic                           response_filter,
    output logic                           table_full,
    output logic                           cam_timeout
);

    localparam int unsigned IDX_W  = $clog2(TABLE_DEPTH);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SRC_LOOKUP,
        SRC_WAIT,
        LEARN,
        DST_LOOKUP,
        DST_WAIT,
        RESPOND
    } state_t;

    state_t                state_q, state_d;
    logic [KEY_WIDTH-1:0]  src_mac_q, src_mac_d;
    logic [KEY_WIDTH-1:0]  dst_mac_q, dst_mac_d;
    logic [PORT_WIDTH-1:0] src_port_q, src_port_d;
    logic [CNT_W-1:0]      learned_count_q, learned_count_d;
    logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [PORT_WIDTH-1:0] port_table_q [TABLE_DEPTH];

    logic                  request_ready_q, request_ready_d;
    logic [KEY_WIDTH-1:0]  cam_key_q, cam_key_d;
    logic                  cam_write_enable_q, cam_write_enable_d;
    logic                  cam_match_enable_q, cam_match_enable_d;
    logic                  response_valid_q, response_valid_d;
    logic [PORT_WIDTH-1:0] response_port_q, response_port_d;
    logic                  response_flood_q, response_flood_d;
    logic                  response_filter_q, response_filter_d;
    logic                  table_full_q, table_full_d;
    logic                  cam_timeout_q, cam_timeout_d;

    logic                  tbl_we;
    logic [IDX_W-1:0]      tbl_idx;
    logic [PORT_WIDTH-1:0] tbl_data;
    logic                  tbl_full;
    logic                  wait_expired;
    logic                  go_dst;
    logic [PORT_WIDTH-1:0] hit_port;

    // Next-state, port-table write and registered-output computation
    always_comb begin
        state_d            = state_q;
        src_mac_d          = src_mac_q;
        dst_mac_d          = dst_mac_q;
        src_port_d         = src_port_q;
        learned_count_d    = learned_count_q;
        wait_cnt_d         = wait_cnt_q;
        cam_key_d          = cam_key_q;
        cam_write_enable_d = 1'b0;
        cam_match_enable_d = 1'b0;
        cam_timeout_d      = 1'b0;
        response_valid_d   = response_valid_q;
        response_port_d    = response_port_q;
        response_flood_d   = response_flood_q;
        response_filter_d  = response_filter_q;
        tbl_we             = 1'b0;
        tbl_idx            = '0;
        tbl_data           = '0;
        go_dst             = 1'b0;
        tbl_full           = (learned_count_q == CNT_W'(TABLE_DEPTH));
        wait_expired       = (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES - 1));
        hit_port           = port_table_q[cam_match_index];

        case (state_q)
            IDLE: begin
                if (request_valid && request_ready_q) begin
                    src_mac_d          = source_mac;
                    dst_mac_d          = destination_mac;
                    src_port_d         = source_port;
                    cam_key_d          = source_mac;
                    cam_match_enable_d = 1'b1;
                    state_d            = SRC_LOOKUP;
                end
            end
            SRC_LOOKUP: begin
                wait_cnt_d = '0;
                state_d    = SRC_WAIT;
            end
            SRC_WAIT: begin
                // A hit wins over a simultaneous miss; a timeout never leads to LEARN
                if (cam_match_valid) begin
                    tbl_we   = 1'b1;
                    tbl_idx  = cam_match_index;
                    tbl_data = src_port_q;
                    go_dst   = 1'b1;
                end else if (cam_no_match) begin
                    if (tbl_full) begin
                        go_dst = 1'b1;
                    end else begin
                        cam_write_enable_d = 1'b1;
                        state_d            = LEARN;
                    end
                end else if (wait_expired) begin
                    cam_timeout_d = 1'b1;
                    go_dst        = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            LEARN: begin
                if (!tbl_full) begin
                    tbl_we          = 1'b1;
                    tbl_idx         = learned_count_q[IDX_W-1:0];
                    tbl_data        = src_port_q;
                    learned_count_d = learned_count_q + CNT_W'(1);
                end
                go_dst = 1'b1;
            end
            DST_LOOKUP: begin
                wait_cnt_d = '0;
                state_d    = DST_WAIT;
            end
            DST_WAIT: begin
                if (cam_match_valid) begin
                    response_valid_d  = 1'b1;
                    response_port_d   = hit_port;
                    response_flood_d  = 1'b0;
                    response_filter_d = (hit_port == src_port_q);
                    state_d           = RESPOND;
                end else if (cam_no_match || wait_expired) begin
                    cam_timeout_d     = !cam_no_match;
                    response_valid_d  = 1'b1;
                    response_port_d   = '0;
                    response_flood_d  = 1'b1;
                    response_filter_d = 1'b0;
                    state_d           = RESPOND;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            RESPOND: begin
                if (response_ready) begin
                    response_valid_d  = 1'b0;
                    response_port_d   = '0;
                    response_flood_d  = 1'b0;
                    response_filter_d = 1'b0;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_dst) begin
            cam_key_d          = dst_mac_q;
            cam_match_enable_d = 1'b1;
            state_d            = DST_LOOKUP;
        end

        request_ready_d = (state_d == IDLE);
        table_full_d    = (learned_count_d == CNT_W'(TABLE_DEPTH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= IDLE;
            src_mac_q          <= '0;
            dst_mac_q          <= '0;
            src_port_q         <= '0;
            learned_count_q    <= '0;
            wait_cnt_q         <= '0;
            port_table_q       <= '{default: '0};
            request_ready_q    <= 1'b0;
            cam_key_q          <= '0;
            cam_write_enable_q <= 1'b0;
            cam_match_enable_q <= 1'b0;
            response_valid_q   <= 1'b0;
            response_port_q    <= '0;
            response_flood_q   <= 1'b0;
            response_filter_q  <= 1'b0;
            table_full_q       <= 1'b0;
            cam_timeout_q      <= 1'b0;
        end else begin
            state_q            <= state_d;
            src_mac_q          <= src_mac_d;
            dst_mac_q          <= dst_mac_d;
            src_port_q         <= src_port_d;
            learned_count_q    <= learned_count_d;
            wait_cnt_q         <= wait_cnt_d;
            if (tbl_we) begin
                port_table_q[tbl_idx] <= tbl_data;
            end
            request_ready_q    <= request_ready_d;
            cam_key_q          <= cam_key_d;
            cam_write_enable_q <= cam_write_enable_d;
            cam_match_enable_q <= cam_match_enable_d;
            response_valid_q   <= response_valid_d;
            response_port_q    <= response_port_d;
            response_flood_q   <= response_flood_d;
            response_filter_q  <= response_filter_d;
            table_full_q       <= table_full_d;
            cam_timeout_q      <= cam_timeout_d;
        end
    end

    assign request_ready    = request_ready_q;
    assign cam_key          = cam_key_q;
    assign cam_write_enable = cam_write_enable_q;
    assign cam_match_enable = cam_match_enable_q;
    assign response_valid   = response_valid_q;
    assign response_port    = response_port_q;
    assign response_flood   = response_flood_q;
    assign response_filter  = response_filter_q;
    assign table_full       = table_full_q;
    assign cam_timeout      = cam_timeout_q;

endmodule

// File: tb/tb_cam_lookup_controller.sv
// Bench for cam_lookup_controller: behavioural CAM stub, reference forwarding model
// and a response scoreboard checked whenever a decision is handed off.
module tb_cam_lookup_controller;

    localparam int unsigned KW = 48;
    localparam int unsigned TD = 32;
    localparam int unsigned PW = 3;
    localparam int unsigned TO = 4;
    localparam int unsigned IW = $clog2(TD);

    logic          clock = 1'b0;
    logic          reset;
    logic          request_valid;
    logic          request_ready;
    logic [KW-1:0] destination_mac;
    logic [KW-1:0] source_mac;
    logic [PW-1:0] source_port;
    logic [KW-1:0] cam_key;
    logic          cam_write_enable;
    logic          cam_match_enable;
    logic [IW-1:0] cam_match_index;
    logic          cam_match_valid;
    logic          cam_no_match;
    logic          response_valid;
    logic          response_ready;
    logic [PW-1:0] response_port;
    logic          response_flood;
    logic          response_filter;
    logic          table_full;
    logic          cam_timeout;

    cam_lookup_controller #(
        .KEY_WIDTH(KW), .TABLE_DEPTH(TD), .PORT_WIDTH(PW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .request_valid(request_valid), .request_ready(request_ready),
        .destination_mac(destination_mac), .source_mac(source_mac), .source_port(source_port),
        .cam_key(cam_key), .cam_write_enable(cam_write_enable), .cam_match_enable(cam_match_enable),
        .cam_match_index(cam_match_index), .cam_match_valid(cam_match_valid), .cam_no_match(cam_no_match),
        .response_valid(response_valid), .response_ready(response_ready),
        .response_port(response_port), .response_flood(response_flood), .response_filter(response_filter),
        .table_full(table_full), .cam_timeout(cam_timeout)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // CAM stub: fills lowest free slot on write, answers one cycle after a match strobe
    logic [KW-1:0] cam_keys [TD];
    bit            cam_used [TD];
    bit            cam_mute  = 1'b0;
    bit            cam_clear = 1'b0;
    int            cam_wr_count = 0;
    logic [KW-1:0] last_wr_key  = '0;
    int            last_wr_slot = -1;
    int            stub_slot, stub_hit;

    always @(posedge clock) begin
        cam_match_valid <= 1'b0;
        cam_no_match    <= 1'b0;
        cam_match_index <= '0;
        if (cam_clear) begin
            for (int i = 0; i < int'(TD); i++) cam_used[i] <= 1'b0;
        end else if (!reset) begin
            if (cam_write_enable) begin
                stub_slot = -1;
                for (int i = 0; i < int'(TD); i++)
                    if (!cam_used[i] && stub_slot < 0) stub_slot = i;
                if (stub_slot >= 0) begin
                    cam_keys[stub_slot] <= cam_key;
                    cam_used[stub_slot] <= 1'b1;
                end
                cam_wr_count <= cam_wr_count + 1;
                last_wr_key  <= cam_key;
                last_wr_slot <= stub_slot;
            end
            if (cam_match_enable && !cam_mute) begin
                stub_hit = -1;
                for (int i = 0; i < int'(TD); i++)
                    if (cam_used[i] && cam_keys[i] == cam_key && stub_hit < 0) stub_hit = i;
                if (stub_hit >= 0) begin
                    cam_match_valid <= 1'b1;
                    cam_match_index <= IW'(stub_hit);
                end else begin
                    cam_no_match <= 1'b1;
                end
            end
        end
    end

    // Reference forwarding model and scoreboard
    typedef struct {
        logic [PW-1:0] port;
        logic          flood;
        logic          filter;
    } resp_t;

    int    ref_port [logic [KW-1:0]];
    int    ref_count = 0;
    resp_t exp_q [$];
    resp_t mon_e;

    function automatic resp_t predict(input logic [KW-1:0] src, input logic [KW-1:0] dst,
                                      input logic [PW-1:0] prt, input bit mute, output bit learn);
        resp_t r;
        r.port = '0; r.flood = 1'b0; r.filter = 1'b0; learn = 1'b0;
        if (!mute) begin
            if (ref_port.exists(src)) ref_port[src] = int'(prt);
            else if (ref_count < int'(TD)) begin
                ref_port[src] = int'(prt);
                ref_count++;
                learn = 1'b1;
            end
        end
        if (mute || !ref_port.exists(dst)) r.flood = 1'b1;
        else if (ref_port[dst] == int'(prt)) begin
            r.filter = 1'b1;
            r.port   = prt;
        end else r.port = PW'(ref_port[dst]);
        return r;
    endfunction

    int  timeout_count = 0;
    bit  prev_we = 1'b0, prev_me = 1'b0, prev_to = 1'b0;

    // Negedge monitor: scoreboard pop on handshake, strobe shape checks
    always @(negedge clock) begin
        if (!reset) begin
            if (response_valid && response_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_response: port=%0d flood=%0b filter=%0b, required no response",
                             response_port, response_flood, response_filter);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (response_flood !== mon_e.flood || response_filter !== mon_e.filter ||
                        (!mon_e.flood && response_port !== mon_e.port)) begin
                        n_fail++;
                        $display("FAIL response_fields: port=%0d flood=%0b filter=%0b, required port=%0d flood=%0b filter=%0b",
                                 response_port, response_flood, response_filter,
                                 mon_e.port, mon_e.flood, mon_e.filter);
                    end
                end
            end
            if (cam_write_enable || cam_match_enable) begin
                n_checks++;
                if ((cam_write_enable && cam_match_enable) || (cam_write_enable && prev_we) ||
                    (cam_match_enable && prev_me)) begin
                    n_fail++;
                    $display("FAIL strobe_shape: we=%0b me=%0b prev_we=%0b prev_me=%0b, required single exclusive strobes",
                             cam_write_enable, cam_match_enable, prev_we, prev_me);
                end
            end
            if (cam_timeout) begin
                timeout_count++;
                n_checks++;
                if (prev_to) begin
                    n_fail++;
                    $display("FAIL timeout_pulse_width: cam_timeout high 2 cycles, required 1");
                end
            end
        end
        prev_we = cam_write_enable;
        prev_me = cam_match_enable;
        prev_to = cam_timeout;
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic send_req(input logic [KW-1:0] src, input logic [KW-1:0] dst, input logic [PW-1:0] prt,
                            input bit push, output int acc_cyc, output bit learn);
        resp_t e;
        int    n;
        n     = 0;
        learn = 1'b0;
        while (!request_ready && n < 50) begin step(); n++; end
        n_checks++;
        if (request_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL request_ready_wait: request_ready=%0b after %0d cycles, required 1", request_ready, n);
        end
        if (push) begin
            e = predict(src, dst, prt, cam_mute, learn);
            exp_q.push_back(e);
        end
        source_mac      = src;
        destination_mac = dst;
        source_port     = prt;
        request_valid   = 1'b1;
        step();
        acc_cyc       = cyc;
        request_valid = 1'b0;
    endtask

    task automatic wait_resp(output int seen_cyc);
        int n;
        n = 0;
        while (!response_valid && n < 60) begin step(); n++; end
        n_checks++;
        if (response_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL response_wait: response_valid=%0b after %0d cycles, required 1", response_valid, n);
        end
        seen_cyc = cyc;
    endtask

    task automatic test_reset();
        reset = 1'b1; cam_clear = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({request_ready, cam_write_enable, cam_match_enable, response_valid, table_full, cam_timeout} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: rr/we/me/rv/full/to=%06b, required 000000",
                     {request_ready, cam_write_enable, cam_match_enable, response_valid, table_full, cam_timeout});
        end
        n_checks++;
        if (cam_key !== '0 || response_port !== '0 || response_flood !== 1'b0 || response_filter !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fields: key=%0h port=%0d flood=%0b filter=%0b, required all 0",
                     cam_key, response_port, response_flood, response_filter);
        end
        reset = 1'b0; cam_clear = 1'b0;
        step();
        n_checks++;
        if (request_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_ready: request_ready=%0b, required 1", request_ready);
        end
    endtask

    logic [KW-1:0] lf_src [5] = '{48'hA, 48'hB, 48'hA, 48'hB, 48'hC};
    logic [KW-1:0] lf_dst [5] = '{48'hB, 48'hA, 48'hB, 48'hA, 48'hC};
    logic [PW-1:0] lf_prt [5] = '{3'd2, 3'd5, 3'd4, 3'd5, 3'd1};

    task automatic test_learn_forward();
        int acc, seen, wr0;
        bit learn;
        for (int i = 0; i < 5; i++) begin
            wr0 = cam_wr_count;
            send_req(lf_src[i], lf_dst[i], lf_prt[i], 1'b1, acc, learn);
            wait_resp(seen);
            n_checks++;
            if (seen + 1 - acc != (learn ? 6 : 5)) begin
                n_fail++;
                $display("FAIL latency_frame%0d: response at T+%0d, required T+%0d", i, seen + 1 - acc, learn ? 6 : 5);
            end
            n_checks++;
            if (cam_wr_count - wr0 != (learn ? 1 : 0)) begin
                n_fail++;
                $display("FAIL learn_count_frame%0d: %0d writes, required %0d", i, cam_wr_count - wr0, learn ? 1 : 0);
            end
            if (learn) begin
                n_checks++;
                if (last_wr_key !== lf_src[i] || last_wr_slot != ref_count - 1) begin
                    n_fail++;
                    $display("FAIL learn_slot_frame%0d: key=%0h slot=%0d, required key=%0h slot=%0d",
                             i, last_wr_key, last_wr_slot, lf_src[i], ref_count - 1);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int acc, seen;
        bit learn;
        logic [PW-1:0] p0;
        logic f0, g0;
        response_ready = 1'b0;
        send_req(48'hD, 48'hA, 3'd3, 1'b1, acc, learn);
        wait_resp(seen);
        p0 = response_port; f0 = response_flood; g0 = response_filter;
        n_checks++;
        if (p0 !== 3'd4 || f0 !== 1'b0 || g0 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_initial: port=%0d flood=%0b filter=%0b, required port=4 flood=0 filter=0", p0, f0, g0);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if (response_valid !== 1'b1 || request_ready !== 1'b0 || response_port !== p0 ||
                response_flood !== f0 || response_filter !== g0) begin
                n_fail++;
                $display("FAIL bp_hold_cycle%0d: rv=%0b rr=%0b port=%0d, required rv=1 rr=0 port=%0d",
                         i, response_valid, request_ready, response_port, p0);
            end
        end
        response_ready = 1'b1;
        repeat (3) step();
    endtask

    task automatic test_timeout();
        int acc, seen, wr0, to0;
        bit learn;
        cam_mute = 1'b1;
        wr0 = cam_wr_count;
        to0 = timeout_count;
        send_req(48'hE, 48'hA, 3'd6, 1'b1, acc, learn);
        wait_resp(seen);
        n_checks++;
        if (response_flood !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_flood: response_flood=%0b, required 1", response_flood);
        end
        step();
        n_checks++;
        if (timeout_count - to0 != 2) begin
            n_fail++;
            $display("FAIL timeout_pulses: %0d pulses, required 2", timeout_count - to0);
        end
        n_checks++;
        if (cam_wr_count != wr0) begin
            n_fail++;
            $display("FAIL timeout_no_learn: %0d writes, required 0", cam_wr_count - wr0);
        end
        cam_mute = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_reset_mid();
        int acc;
        bit learn;
        send_req(48'hF, 48'hA, 3'd1, 1'b0, acc, learn);
        step();
        reset = 1'b1; cam_clear = 1'b1;
        step();
        n_checks++;
        if ({request_ready, cam_write_enable, cam_match_enable, response_valid, table_full, cam_timeout} !== 6'b0 ||
            cam_key !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: rr/we/me/rv/full/to=%06b key=%0h, required all 0",
                     {request_ready, cam_write_enable, cam_match_enable, response_valid, table_full, cam_timeout}, cam_key);
        end
        reset = 1'b0; cam_clear = 1'b0;
        ref_port.delete();
        ref_count = 0;
        step();
        n_checks++;
        if (cam_write_enable !== 1'b0 || cam_match_enable !== 1'b0 || response_valid !== 1'b0 || request_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_reset_idle: we=%0b me=%0b rv=%0b rr=%0b, required 0 0 0 1",
                     cam_write_enable, cam_match_enable, response_valid, request_ready);
        end
    endtask

    task automatic test_table_full();
        int acc, seen, wr0;
        bit learn;
        logic [KW-1:0] src, dst;
        wr0 = cam_wr_count;
        for (int i = 0; i < int'(TD); i++) begin
            src = KW'(48'h100 + i);
            dst = (i == 0) ? KW'(48'h1FF) : KW'(48'h100 + i - 1);
            send_req(src, dst, PW'(i % 8), 1'b1, acc, learn);
            wait_resp(seen);
            n_checks++;
            if (table_full !== (i == int'(TD) - 1)) begin
                n_fail++;
                $display("FAIL table_full_fill%0d: table_full=%0b, required %0b", i, table_full, i == int'(TD) - 1);
            end
        end
        n_checks++;
        if (cam_wr_count - wr0 != int'(TD) || last_wr_slot != int'(TD) - 1) begin
            n_fail++;
            $display("FAIL fill_writes: %0d writes last slot %0d, required %0d writes last slot %0d",
                     cam_wr_count - wr0, last_wr_slot, TD, TD - 1);
        end
        wr0 = cam_wr_count;
        send_req(48'h200, 48'h100, 3'd7, 1'b1, acc, learn);
        wait_resp(seen);
        n_checks++;
        if (cam_wr_count != wr0 || table_full !== 1'b1 || response_port !== 3'd0 || response_flood !== 1'b0) begin
            n_fail++;
            $display("FAIL full_new_source: writes=%0d full=%0b port=%0d flood=%0b, required 0 1 0 0",
                     cam_wr_count - wr0, table_full, response_port, response_flood);
        end
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        request_valid   = 1'b0;
        response_ready  = 1'b1;
        source_mac      = '0;
        destination_mac = '0;
        source_port     = '0;
        test_reset();
        test_learn_forward();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_table_full();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_lookup_controller.md
CAM_LOOKUP_CONTROLLER -- requirements
Module: cam_lookup_controller

Interface
REQ-001 Parameter KEY_WIDTH, default 48: MAC address width.
REQ-002 Parameter TABLE_DEPTH, default 32: CAM slot count.
REQ-003 Parameter PORT_WIDTH, default 3: switch port number width.
REQ-004 Parameter TIMEOUT_CYCLES, default 4: maximum wait for a CAM result.
REQ-005 Port clock, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port request_valid, input, 1: a frame header is presented.
REQ-008 Port request_ready, output, 1: high only in IDLE.
REQ-009 Port destination_mac, input, KEY_WIDTH: destination address of the frame.
REQ-010 Port source_mac, input, KEY_WIDTH: source address of the frame.
REQ-011 Port source_port, input, PORT_WIDTH: ingress port of the frame.
REQ-012 Port cam_key, output, KEY_WIDTH: key driven to the CAM.
REQ-013 Port cam_write_enable, output, 1: learn strobe; the CAM fills its lowest free slot.
REQ-014 Port cam_match_enable, output, 1: lookup strobe.
REQ-015 Port cam_match_index, input, clog2(TABLE_DEPTH): slot index of the hit.
REQ-016 Port cam_match_valid, input, 1: hit result, registered one cycle after cam_match_enable.
REQ-017 Port cam_no_match, input, 1: miss result, registered one cycle after cam_match_enable.
REQ-018 Port response_valid, output, 1: a forwarding decision is available.
REQ-019 Port response_ready, input, 1: the consumer accepts the decision.
REQ-020 Port response_port, output, PORT_WIDTH: egress port; valid only when response_flood=0.
REQ-021 Port response_flood, output, 1: the destination is unknown; flood to all ports.
REQ-022 Port response_filter, output, 1: the destination is on the ingress port; drop the frame.
REQ-023 Port table_full, output, 1: learned_count equals TABLE_DEPTH.
REQ-024 Port cam_timeout, output, 1: one-cycle pulse when a CAM wait times out.

Function
REQ-025 The FSM SHALL have states IDLE, SRC_LOOKUP, SRC_WAIT, LEARN, DST_LOOKUP, DST_WAIT and RESPOND.
REQ-026 IDLE, on request_valid && request_ready: register the three request fields and go to SRC_LOOKUP.
REQ-027 SRC_LOOKUP (1 cycle): cam_match_enable=1, cam_key=source MAC; then go to SRC_WAIT.
REQ-028 SRC_WAIT: hold cam_key; on a hit, store source port in port_table[cam_match_index] (station move/refresh).
REQ-029 SRC_WAIT: on a hit, go to DST_LOOKUP.
REQ-030 SRC_WAIT: on a miss with the table not full, go to LEARN.
REQ-031 SRC_WAIT: on a miss with the table full, skip learning and go to DST_LOOKUP.
REQ-032 LEARN (1 cycle): cam_write_enable=1 with cam_key=source MAC.
REQ-033 LEARN: write port_table[learned_count]=source port and increment learned_count; then go to DST_LOOKUP.
REQ-034 DST_LOOKUP/DST_WAIT: same as the source pair, with cam_key=destination MAC.
REQ-035 DST_WAIT: on a hit with port_table[idx] equal to the source port, response_filter=1.
REQ-036 DST_WAIT: on a hit otherwise, response_port=port_table[idx].
REQ-037 DST_WAIT: on a miss, response_flood=1.
REQ-038 DST_WAIT: after the result, go to RESPOND.
REQ-039 RESPOND: hold response_valid and the response fields stable until response_ready.
REQ-040 RESPOND: go to IDLE in the cycle after the handshake.
REQ-041 In SRC_WAIT and DST_WAIT, a wait counter SHALL start at 0.
REQ-042 If TIMEOUT_CYCLES cycles elapse without a CAM result: pulse cam_timeout and treat the lookup as a miss.
REQ-043 A source-lookup timeout SHALL NOT trigger LEARN.
REQ-044 If cam_match_valid and cam_no_match are both high, the hit SHALL take precedence.
REQ-045 A CAM result outside a WAIT state SHALL be ignored.
REQ-046 cam_write_enable and cam_match_enable SHALL never be high together.
REQ-047 cam_write_enable and cam_match_enable SHALL each be high for exactly one cycle per strobe.
REQ-048 Latency, accept edge T, no learning: response_valid high at T+5.
REQ-049 Latency, accept edge T, with learning: response_valid high at T+6.
REQ-050 learned_count SHALL be clog2(TABLE_DEPTH)+1 bits wide.
REQ-051 learned_count SHALL saturate at TABLE_DEPTH and never wrap.
REQ-052 A destination equal to the source (learned this frame) SHALL hit and set response_filter.

Reset
REQ-053 When reset=1 at a clock edge: state=IDLE, learned_count=0 and all port_table entries=0.
REQ-054 Reset SHALL also clear all outputs and the wait counter to 0.
REQ-055 Reset mid-operation SHALL abandon the frame with no response and no CAM strobe in the next cycle.
REQ-056 Reset SHALL NOT clear the CAM; the system resets both blocks together.

Verification
REQ-057 Empty table, request src=0xA, dst=0xB, port=2 -> one learn of 0xA into slot 0; response_flood=1 at T+6.
REQ-058 Then request src=0xB, dst=0xA, port=5 -> learn 0xB into slot 1; response_port=2, flood=0, filter=0.
REQ-059 Repeat src=0xA from port 4, dst=0xB -> no learn; port_table[0]=4; response_port=5 at T+5.
REQ-060 Fill 32 distinct sources, then a new source -> table_full=1, no cam_write_enable, response still produced.
REQ-061 CAM stub never answers -> two cam_timeout pulses, no learn, response_flood=1.
REQ-062 response_ready held low 10 cycles -> fields stable, request_ready=0 throughout; reset mid-SRC_WAIT -> IDLE, all outputs 0.
